pll_step_sequencer: RTL and testbench

Frequency-step controller for the SDRAM memory tester. It sits upstream of the `pll_reconfig` megafunction and converts debounced user buttons and tester pass/fail status into a selected PLL step index. It sequences the ROM-load / reconfig / recovery handshake and keeps the elapsed-time counters shown on the VGA overlay. Auto mode sweeps from the fastest step toward the slowest, advancing on the first failure.

---
 rtl/memtest_pkg.sv | 17 +
 rtl/pll_step_sequencer_if.sv | 28 ++
 rtl/bcd_minute_counter.sv | 46 ++++
 rtl/pll_step_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_pll_step_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memtest_pkg.sv
// Shared definitions for the memory-tester PLL control path.
// NUM_STEPS / DEFAULT_POS are also consumed by the top-level ROM mux and
// the frequency label table, so they live here rather than in one module.
package memtest_pkg;

  localparam int unsigned NUM_STEPS   = 11;  // step 0 = 167 MHz (fastest)
  localparam int unsigned DEFAULT_POS = 7;   // 100 MHz

  // Reconfiguration handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_FREE,
    RUN
  } seq_state_e;

endpackage

// File: rtl/pll_step_sequencer_if.sv
// Handshake bundle between the step sequencer and the pll_reconfig block.
//   cfg_busy           : pll_reconfig busy
//   cfg_write_from_rom : single-cycle pulse, start loading scan chain from ROM
//   cfg_reconfig       : single-cycle pulse, apply the loaded configuration
//   cfg_reset          : single-cycle pulse, abort a hung reconfiguration
// master = sequencer side, slave = pll_reconfig side.
interface pll_step_sequencer_if;

  logic cfg_busy;
  logic cfg_write_from_rom;
  logic cfg_reconfig;
  logic cfg_reset;

  modport master (
    input  cfg_busy,
    output cfg_write_from_rom,
    output cfg_reconfig,
    output cfg_reset
  );

  modport slave (
    output cfg_busy,
    input  cfg_write_from_rom,
    input  cfg_reconfig,
    input  cfg_reset
  );

endinterface

// File: rtl/bcd_minute_counter.sv
// Four-digit BCD up-counter for the elapsed-minutes display.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one minute
//   bcd        : 4-digit packed BCD value, 9999 wraps to 0000
module bcd_minute_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] bcd
);

  logic [15:0] bcd_q, bcd_d;
  logic        carry;

  // Ripple the increment through the digits; a digit at 9 rolls to 0 and
  // passes the carry on, the first digit below 9 absorbs it.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b0;
    if (clr) begin
      bcd_d = '0;
    end else if (en) begin
      carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (bcd_q[i*4 +: 4] == 4'd9) begin
            bcd_d[i*4 +: 4] = 4'd0;
          end else begin
            bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcd_q <= '0;
    else        bcd_q <= bcd_d;
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/pll_step_sequencer.sv
// PLL frequency-step controller for the SDRAM memory tester.
// Turns button edges, auto-sweep requests and tester pass/fail status into a
// PLL step index, sequences the pll_reconfig ROM-load / reconfig / recovery
// handshake, and keeps the elapsed-time counters for the VGA overlay.
//   clock_50_i, rst_n        : clock, asynchronous active-low reset
//   btn_up/btn_down/btn_auto : debounced buttons, act on rising edge
//   start_auto               : level, forces an auto sweep from step 0
//   pass_nz, fail_nz         : tester pass / fail counts nonzero
//   cfg                      : pll_reconfig handshake (master side)
//   pos                      : current step index / ROM mux select
//   auto                     : auto sweep active
//   recfg                    : reconfiguration in progress
//   mins                     : elapsed minutes, 4-digit BCD
//   tenths                   : elapsed tenth-seconds, binary
module pll_step_sequencer #(
  parameter int unsigned NUM_STEPS   = memtest_pkg::NUM_STEPS,
  parameter int unsigned DEFAULT_POS = memtest_pkg::DEFAULT_POS,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned SETTLE_CYC  = 65536,
  parameter int unsigned TICK_DIV    = 5000000
) (
  input  logic                 clock_50_i,
  input  logic                 rst_n,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_auto,
  input  logic                 start_auto,
  input  logic                 pass_nz,
  input  logic                 fail_nz,
  pll_step_sequencer_if.master cfg,
  output logic [3:0]           pos,
  output logic                 auto,
  output logic                 recfg,
  output logic [15:0]          mins,
  output logic [15:0]          tenths
);

  import memtest_pkg::*;

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  localparam logic [3:0]       LAST_POS = 4'(NUM_STEPS - 1);
  localparam logic [3:0]       RST_POS  = 4'(DEFAULT_POS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic             auto_q, auto_d;
  logic             recfg_q, recfg_d;
  logic             wr_q, wr_d, rcf_q, rcf_d, crst_q, crst_d;
  logic             btn_up_q, btn_down_q, btn_auto_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             seen_q, seen_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       sub_q, sub_d;
  logic [15:0]      tenths_q, tenths_d;
  logic             min_en, done, accept;
  logic             up_edge, down_edge, auto_edge;

  assign up_edge   = btn_up   & ~btn_up_q;
  assign down_edge = btn_down & ~btn_down_q;
  assign auto_edge = btn_auto & ~btn_auto_q;

  // Handshake sequencer.
  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    rcf_d   = 1'b0;
    crst_d  = 1'b0;
    timer_d = timer_q;
    seen_d  = seen_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (recfg_q) begin
        wr_d    = 1'b1;
        state_d = LOAD;
      end
      LOAD: state_d = WAIT_FREE;
      WAIT_FREE: if (!cfg.cfg_busy) begin
        rcf_d   = 1'b1;
        timer_d = TMR_LOAD;
        seen_d  = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer_q - TMR_W'(1);
        seen_d  = seen_q | cfg.cfg_busy;
        // Timeout is judged on the decremented value, which places the
        // cfg_reset pulse TIMEOUT_CYC-1 cycles after cfg_reconfig.
        if (seen_q && !cfg.cfg_busy) begin
          done = 1'b1;
        end else if (timer_d == TMR_W'(1)) begin
          crst_d = 1'b1;
          done   = 1'b1;
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Step requests, prioritised top to bottom; ignored while reconfiguring.
  always_comb begin
    pos_d    = pos_q;
    auto_d   = auto_q;
    recfg_d  = recfg_q;
    accept   = 1'b0;
    settle_d = (settle_q != '0) ? settle_q - SET_W'(1) : settle_q;
    if (done) begin
      recfg_d  = 1'b0;
      settle_d = SET_LOAD;
    end else if (!recfg_q) begin
      accept = 1'b1;
      if (start_auto) begin
        pos_d  = '0;
        auto_d = 1'b1;
      end else if (auto_q && pass_nz && fail_nz && settle_q == '0 && pos_q < LAST_POS) begin
        pos_d = pos_q + 4'd1;
      end else if (auto_edge && auto_q) begin
        auto_d = 1'b0;
      end else if (auto_edge) begin
        pos_d  = '0;
        auto_d = 1'b1;
      end else if (down_edge && pos_q < LAST_POS) begin
        pos_d  = pos_q + 4'd1;
        auto_d = 1'b0;
      end else if (up_edge && pos_q != '0) begin
        pos_d  = pos_q - 4'd1;
        auto_d = 1'b0;
      end else begin
        accept = 1'b0;
      end
      recfg_d = accept;
    end
  end

  // Elapsed-time dividers, held cleared during reconfiguration.
  always_comb begin
    div_d    = div_q;
    sub_d    = sub_q;
    tenths_d = tenths_q;
    min_en   = 1'b0;
    if (recfg_q) begin
      div_d    = '0;
      sub_d    = '0;
      tenths_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d    = '0;
      tenths_d = tenths_q + 16'd1;
      if (sub_q == 10'd599) begin
        sub_d  = '0;
        min_en = 1'b1;
      end else begin
        sub_d = sub_q + 10'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock_50_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos_q      <= RST_POS;
      auto_q     <= 1'b0;
      recfg_q    <= 1'b0;
      wr_q       <= 1'b0;
      rcf_q      <= 1'b0;
      crst_q     <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      btn_auto_q <= 1'b0;
      timer_q    <= '0;
      seen_q     <= 1'b0;
      settle_q   <= '0;
      div_q      <= '0;
      sub_q      <= '0;
      tenths_q   <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      auto_q     <= auto_d;
      recfg_q    <= recfg_d;
      wr_q       <= wr_d;
      rcf_q      <= rcf_d;
      crst_q     <= crst_d;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      btn_auto_q <= btn_auto;
      timer_q    <= timer_d;
      seen_q     <= seen_d;
      settle_q   <= settle_d;
      div_q      <= div_d;
      sub_q      <= sub_d;
      tenths_q   <= tenths_d;
    end
  end

  bcd_minute_counter u_minutes (
    .clk   (clock_50_i),
    .rst_n (rst_n),
    .clr   (recfg_q),
    .en    (min_en),
    .bcd   (mins)
  );

  assign cfg.cfg_write_from_rom = wr_q;
  assign cfg.cfg_reconfig       = rcf_q;
  assign cfg.cfg_reset          = crst_q;
  assign pos                    = pos_q;
  assign auto                   = auto_q;
  assign recfg                  = recfg_q;
  assign tenths                 = tenths_q;

endmodule

// File: tb/tb_pll_step_sequencer.sv
module tb_pll_step_sequencer;

  localparam int T  = 40;   // TIMEOUT_CYC
  localparam int S  = 50;   // SETTLE_CYC
  localparam int TD = 4;    // TICK_DIV
  localparam int NS = 11;
  localparam int DP = 7;

  logic clk = 1'b0;
  logic rst_n, btn_up, btn_down, btn_auto, start_auto, pass_nz, fail_nz, man_busy;
  logic [3:0]  pos;
  logic        auto, recfg;
  logic [15:0] mins, tenths, bcd_out;
  logic        bcd_en, bcd_clr;

  int total = 0, bad = 0, ncyc = 0, bcnt = 0;
  bit cmp_en = 1'b0, pll_emul = 1'b0;

  always #5 clk = ~clk;

  pll_step_sequencer_if cfg_if ();
  assign cfg_if.cfg_busy = man_busy;

  pll_step_sequencer #(
    .NUM_STEPS(NS), .DEFAULT_POS(DP), .TIMEOUT_CYC(T), .SETTLE_CYC(S), .TICK_DIV(TD)
  ) dut (
    .clock_50_i(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_auto(btn_auto), .start_auto(start_auto), .pass_nz(pass_nz), .fail_nz(fail_nz),
    .cfg(cfg_if), .pos(pos), .auto(auto), .recfg(recfg), .mins(mins), .tenths(tenths)
  );

  bcd_minute_counter u_bcd (.clk(clk), .rst_n(rst_n), .clr(bcd_clr), .en(bcd_en), .bcd(bcd_out));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // ---------------- behavioural model (timestamp based) ----------------
  int  m_cyc, m_pos, m_run, t_acc, t_rcf, settle_zero;
  bit  m_auto, m_recfg, m_wr, m_rcf, m_rst, rcf_done, seen, p_up, p_dn, p_au;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_pos = DP; m_auto = 0; m_recfg = 0; m_wr = 0; m_rcf = 0; m_rst = 0;
      m_run = 0; t_acc = 0; t_rcf = 0; settle_zero = 0; rcf_done = 0; seen = 0;
      p_up = 0; p_dn = 0; p_au = 0;
    end else begin
      bit o_recfg, e_up, e_dn, e_au, acc;
      m_cyc++;
      o_recfg = m_recfg;
      e_up = btn_up & !p_up; e_dn = btn_down & !p_dn; e_au = btn_auto & !p_au;
      m_wr = 0; m_rcf = 0; m_rst = 0;
      if (o_recfg) m_run = 0; else m_run++;
      if (o_recfg) begin
        if (m_cyc == t_acc + 1) m_wr = 1;
        else if (!rcf_done) begin
          if (m_cyc >= t_acc + 3 && !cfg_if.cfg_busy) begin
            m_rcf = 1; rcf_done = 1; t_rcf = m_cyc; seen = 0;
          end
        end else begin
          if (seen && !cfg_if.cfg_busy) begin
            m_recfg = 0; settle_zero = m_cyc + S;
          end else if ((m_cyc - 1) - t_rcf == T - 2) begin
            m_rst = 1; m_recfg = 0; settle_zero = m_cyc + S;
          end else if (cfg_if.cfg_busy) seen = 1;
        end
      end else begin
        acc = 1;
        if (start_auto) begin m_pos = 0; m_auto = 1; end
        else if (m_auto && pass_nz && fail_nz && (m_cyc - 1) >= settle_zero && m_pos < NS - 1) m_pos++;
        else if (e_au && m_auto) m_auto = 0;
        else if (e_au) begin m_pos = 0; m_auto = 1; end
        else if (e_dn && m_pos < NS - 1) begin m_pos++; m_auto = 0; end
        else if (e_up && m_pos > 0) begin m_pos--; m_auto = 0; end
        else acc = 0;
        if (acc) begin m_recfg = 1; t_acc = m_cyc; rcf_done = 0; end
      end
      p_up = btn_up; p_dn = btn_down; p_au = btn_auto;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pos", 32'(pos), 32'(m_pos));
      chk("m_auto", 32'(auto), 32'(m_auto));
      chk("m_recfg", 32'(recfg), 32'(m_recfg));
      chk("m_wr", 32'(cfg_if.cfg_write_from_rom), 32'(m_wr));
      chk("m_rcf", 32'(cfg_if.cfg_reconfig), 32'(m_rcf));
      chk("m_rst", 32'(cfg_if.cfg_reset), 32'(m_rst));
      chk("m_tenths", 32'(tenths), 32'((m_run / TD) % 65536));
      chk("m_mins", 32'(mins), 32'(to_bcd((m_run / TD / 600) % 10000)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (pll_emul) begin
      if (cfg_if.cfg_reconfig) bcnt = 5;
      if (bcnt > 0) begin man_busy = 1'b1; bcnt--; end else man_busy = 1'b0;
    end
  endtask

  function automatic logic sig(input int id);
    case (id)
      0: return cfg_if.cfg_write_from_rom;
      1: return cfg_if.cfg_reconfig;
      2: return cfg_if.cfg_reset;
      default: return recfg;
    endcase
  endfunction

  task automatic wait_sig(input int id, input logic v, input int lim, input string nm, output int t);
    int n;
    n = 0;
    do begin tick(); n++; end while (sig(id) !== v && n < lim);
    chk(nm, 32'(sig(id)), 32'(v));
    t = ncyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t1, t2, b, last, nrcf, n, npulse;
    rst_n = 0; btn_up = 0; btn_down = 0; btn_auto = 0; start_auto = 0;
    pass_nz = 0; fail_nz = 0; man_busy = 0; bcd_en = 0; bcd_clr = 0;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_pos", 32'(pos), 7);
    chk("rst_auto", 32'(auto), 0);
    chk("rst_recfg", 32'(recfg), 0);
    chk("rst_pulses", 32'({cfg_if.cfg_write_from_rom, cfg_if.cfg_reconfig, cfg_if.cfg_reset}), 0);
    chk("rst_mins", 32'(mins), 0);
    chk("rst_tenths", 32'(tenths), 0);
    #2 rst_n = 1;
    repeat (5) tick();

    // btn_up: 7 -> 6, ROM load, reconfig, busy 20 cycles
    btn_up = 1; k = ncyc;
    tick();
    chk("up_pos", 32'(pos), 6);
    chk("up_recfg", 32'(recfg), 1);
    tick();
    chk("up_wr", 32'(cfg_if.cfg_write_from_rom), 1);
    wait_sig(1, 1'b1, 10, "up_rcf_seen", t1);
    chk("up_rcf_lat", 32'(t1 - k), 4);
    man_busy = 1;
    repeat (20) tick();
    man_busy = 0; b = ncyc;
    chk("busy_recfg_held", 32'(recfg), 1);
    wait_sig(3, 1'b0, 10, "busy_recfg_fall", t2);
    chk("busy_fall_lat", 32'(t2 - b), 1);
    btn_up = 0; tick();

    // btn_down: 6 -> 7, busy never asserts -> timeout
    btn_down = 1;
    wait_sig(1, 1'b1, 10, "to_rcf_seen", t1);
    wait_sig(2, 1'b1, T + 5, "to_rst_seen", t2);
    chk("to_gap", 32'(t2 - t1), 32'(T - 1));
    chk("to_recfg", 32'(recfg), 0);
    chk("to_pos", 32'(pos), 7);
    btn_down = 0; repeat (3) tick();

    // up and down in the same cycle at 7 -> down wins; up during recfg dropped
    btn_up = 1; btn_down = 1;
    tick();
    chk("both_pos", 32'(pos), 8);
    chk("both_recfg", 32'(recfg), 1);
    btn_up = 0; tick();
    btn_up = 1; tick(); tick();
    chk("drop_pos", 32'(pos), 8);
    wait_sig(2, 1'b1, T + 10, "drop_rst_seen", t2);
    repeat (3) tick();
    chk("drop_pos_after", 32'(pos), 8);
    btn_up = 0; btn_down = 0; tick();

    // auto sweep 0 -> 10 with a responding pll_reconfig
    pll_emul = 1;
    start_auto = 1; tick(); start_auto = 0;
    chk("sa_pos", 32'(pos), 0);
    chk("sa_auto", 32'(auto), 1);
    pass_nz = 1; fail_nz = 1;
    last = 0; nrcf = 0; n = 0;
    while (!(pos == 4'd10 && recfg == 1'b0) && n < 3000) begin
      tick(); n++;
      if (cfg_if.cfg_reconfig) nrcf++;
      if (int'(pos) != last) begin
        chk("auto_step", 32'(pos), 32'(last + 1));
        last = int'(pos);
      end
    end
    chk("auto_reach", 32'(pos), 10);
    repeat (200) begin tick(); if (cfg_if.cfg_reconfig) nrcf++; end
    chk("auto_rcf_count", 32'(nrcf), 11);
    chk("auto_hold_pos", 32'(pos), 10);
    chk("auto_still", 32'(auto), 1);

    // btn_auto while auto -> auto off, pos kept
    btn_auto = 1; tick();
    chk("aoff_auto", 32'(auto), 0);
    chk("aoff_pos", 32'(pos), 10);
    chk("aoff_recfg", 32'(recfg), 1);
    btn_auto = 0; pass_nz = 0; fail_nz = 0;
    wait_sig(3, 1'b0, 60, "aoff_recfg_fall", t2);

    // one full minute of idle time
    repeat (600 * TD - 1) tick();
    chk("min_pre_tenths", 32'(tenths), 599);
    chk("min_pre_mins", 32'(mins), 0);
    tick();
    chk("min_tenths", 32'(tenths), 600);
    chk("min_mins", 32'(mins), 32'h0001);

    // BCD counter through 9999 and the wrap
    bcd_en = 1;
    for (int i = 1; i <= 10000; i++) begin
      tick();
      chk("bcd_seq", 32'(bcd_out), 32'(to_bcd(i % 10000)));
      if (i == 9999) chk("bcd_9999", 32'(bcd_out), 32'h9999);
    end
    chk("bcd_wrap", 32'(bcd_out), 32'h0000);
    tick();
    bcd_en = 0; bcd_clr = 1; tick(); bcd_clr = 0;
    chk("bcd_clr", 32'(bcd_out), 0);

    // reset while in RUN
    pll_emul = 0; man_busy = 0;
    btn_up = 1;
    wait_sig(1, 1'b1, 10, "mr_rcf_seen", t1);
    btn_up = 0;
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    chk("mr_pos", 32'(pos), 7);
    chk("mr_recfg", 32'(recfg), 0);
    chk("mr_pulses", 32'({cfg_if.cfg_write_from_rom, cfg_if.cfg_reconfig, cfg_if.cfg_reset}), 0);
    tick(); tick();
    #2 rst_n = 1;
    npulse = 0;
    repeat (60) begin
      tick();
      if (cfg_if.cfg_write_from_rom || cfg_if.cfg_reconfig || cfg_if.cfg_reset) npulse++;
    end
    chk("mr_no_pulse", 32'(npulse), 0);
    chk("mr_pos_after", 32'(pos), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
